dcache_port_arbiter: RTL and testbench
======================================

Name: dcache_port_arbiter

Overview:
- Shares the single data-cache request port between the LSU and the MMU page-table walker (PTW).
- Sits between the LSU/MMU and the data cache. It replaces direct PTW↔dcache wiring and gives the LSU a path to the same port.
- Owns one outstanding dcache transaction at a time and registers every outgoing request.
- Steers the ack and read data back to the owning requester, and drains transactions whose owner aborts (flush/kill).

Parameters:
- PA_WIDTH, 34: physical address width.
- DATA_WIDTH, 32: dcache data width.
- STARVE_MAX, 4: consecutive PTW grants allowed while the LSU waits, before the LSU is forced a grant (range 1..15).

Ports:
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  clock
- lsu_req_i  in  1  LSU request, held until lsu_ack_o or lsu_flush_i
- lsu_addr_i  in  PA_WIDTH  LSU physical address
- lsu_w_en_i  in  1  LSU store (1) / load (0)
- lsu_wdata_i  in  DATA_WIDTH  LSU store data
- lsu_sel_byte_i  in  DATA_WIDTH/8  LSU byte enables
- lsu_flush_i  in  1  LSU abort (pipeline flush)
- lsu_ack_o  out  1  LSU completion pulse
- lsu_rdata_o  out  DATA_WIDTH  LSU load data, valid with lsu_ack_o
- ptw_req_i  in  1  PTW PTE-read request, held until ptw_ack_o or ptw_kill_i
- ptw_addr_i  in  PA_WIDTH  PTE physical address
- ptw_kill_i  in  1  PTW abort (walk killed)
- ptw_ack_o  out  1  PTW completion pulse
- ptw_rdata_o  out  DATA_WIDTH  PTE data, valid with ptw_ack_o
- dcache_req_o  out  1  request to dcache, held until dcache_ack_i
- dcache_addr_o  out  PA_WIDTH  registered address
- dcache_w_en_o  out  1  registered write enable (always 0 for PTW)
- dcache_wdata_o  out  DATA_WIDTH  registered write data
- dcache_sel_byte_o  out  DATA_WIDTH/8  registered byte enables (all ones for PTW)
- dcache_ack_i  in  1  dcache completion pulse (one cycle)
- dcache_rdata_i  in  DATA_WIDTH  dcache read data, valid with dcache_ack_i

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, starve counter 0.
  - all dcache_* outputs 0; lsu_ack_o and ptw_ack_o 0.
  - A reset mid-transaction abandons it; any later dcache_ack_i is ignored in IDLE.
- States: IDLE, LSU_BUSY, PTW_BUSY, DRAIN.
- IDLE:
  - eligible_lsu = lsu_req_i & ~lsu_flush_i; eligible_ptw = ptw_req_i & ~ptw_kill_i.
  - Priority is PTW > LSU, except when eligible_lsu and starve counter == STARVE_MAX; then the LSU wins.
  - On a grant in cycle N: latch the winner's addr/w_en/wdata/sel_byte into the output registers, set dcache_req_o=1 in cycle N+1, and go to the matching BUSY state.
- Starve counter:
  - increments (saturating at STARVE_MAX) on each PTW grant while lsu_req_i=1;
  - clears on an LSU grant, or when lsu_req_i=0 in IDLE.
- BUSY:
  - dcache_req_o and the address/data registers stay stable until dcache_ack_i.
  - On dcache_ack_i with no abort: pulse the owner's ack combinationally in the same cycle, pass dcache_rdata_i to the owner's rdata, drop dcache_req_o next cycle, and return to IDLE.
  - New grant earliest the cycle after the ack, so back-to-back requests see 1 idle cycle on dcache_req_o.
- Owner abort (lsu_flush_i in LSU_BUSY, ptw_kill_i in PTW_BUSY):
  - abort without dcache_ack_i in the same cycle: go to DRAIN.
  - abort in the same cycle as dcache_ack_i: ack suppressed, go to IDLE.
  - A non-owner abort has no effect on the transaction.
- DRAIN:
  - keep dcache_req_o asserted until dcache_ack_i; suppress both requester acks; then go to IDLE.
  - Store writes may complete in the cache; the LSU is responsible for not issuing speculative stores.
- Ack outputs are never asserted outside the matching BUSY state. At most one of lsu_ack_o / ptw_ack_o is high in any cycle.
- rdata outputs are 0 when the corresponding ack is 0.

Decomposition:
- Shared package mmu_defs additions:
  - typedef type_lsu2dcache_arb_s, type_ptw2dcache_arb_s, type_dcache_arb2mem_s (bundling the port groups above);
  - state enum type_dcache_arb_states_e;
  - constant DCACHE_ARB_STARVE_MAX.
- Single module; no sub-module. The starve counter and state machine are small enough to stay inline.

Test Plan:
- Single LSU load, addr 0x0_8000_1004: lsu_req_i in cycle 0 → dcache_req_o=1 in cycle 1 with addr 0x0_8000_1004 and w_en 0. Ack in cycle 4 with rdata 0xDEADBEEF → lsu_ack_o=1 and lsu_rdata_o=0xDEADBEEF in cycle 4. dcache_req_o=0 in cycle 5.
- Simultaneous LSU and PTW requests in IDLE → PTW granted first with sel_byte 4'hF and w_en 0; LSU granted the cycle after the PTW ack.
- Starvation: PTW re-requests continuously with LSU pending, STARVE_MAX=4 → grants go PTW×4 then LSU×1 and the counter returns to 0.
- ptw_kill_i 2 cycles into PTW_BUSY, ack 3 cycles later → dcache_req_o held until the ack, ptw_ack_o never asserts, state IDLE the cycle after the ack.
- lsu_flush_i in the same cycle as dcache_ack_i → lsu_ack_o=0, next grant possible the following cycle; lsu_flush_i in IDLE with lsu_req_i=1 → no grant.
- Assert rst_n=0 mid LSU_BUSY → all outputs 0 immediately; a subsequent stray dcache_ack_i produces no requester ack.

Source files
------------

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared definitions for the data-cache port arbiter: port bundles, FSM states,
// starvation limit and the saturating starve-counter helper.
package dcache_port_arbiter_pkg;

   localparam int unsigned DCACHE_ARB_PA_WIDTH   = 34;
   localparam int unsigned DCACHE_ARB_DATA_WIDTH = 32;
   localparam int unsigned DCACHE_ARB_SEL_WIDTH  = DCACHE_ARB_DATA_WIDTH / 8;
   localparam int unsigned DCACHE_ARB_STARVE_MAX = 4;
   localparam int unsigned DCACHE_ARB_CNT_WIDTH  = 4;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_LSU_BUSY = 2'd1,
      ARB_PTW_BUSY = 2'd2,
      ARB_DRAIN    = 2'd3
   } type_dcache_arb_states_e;

   typedef struct packed {
      logic                             req;
      logic [DCACHE_ARB_PA_WIDTH-1:0]   addr;
      logic                             w_en;
      logic [DCACHE_ARB_DATA_WIDTH-1:0] wdata;
      logic [DCACHE_ARB_SEL_WIDTH-1:0]  sel_byte;
      logic                             flush;
   } type_lsu2dcache_arb_s;

   typedef struct packed {
      logic                           req;
      logic [DCACHE_ARB_PA_WIDTH-1:0] addr;
      logic                           kill;
   } type_ptw2dcache_arb_s;

   typedef struct packed {
      logic                             req;
      logic [DCACHE_ARB_PA_WIDTH-1:0]   addr;
      logic                             w_en;
      logic [DCACHE_ARB_DATA_WIDTH-1:0] wdata;
      logic [DCACHE_ARB_SEL_WIDTH-1:0]  sel_byte;
   } type_dcache_arb2mem_s;

   // Saturating increment of the LSU starvation counter.
   function automatic logic [DCACHE_ARB_CNT_WIDTH-1:0] starve_inc(
      input logic [DCACHE_ARB_CNT_WIDTH-1:0] cnt,
      input logic [DCACHE_ARB_CNT_WIDTH-1:0] lim
   );
      return (cnt >= lim) ? lim : DCACHE_ARB_CNT_WIDTH'(cnt + 1'b1);
   endfunction

endpackage

// File: rtl/dcache_port_arbiter.sv
// Shares the single data-cache request port between the LSU and the PTW,
// one outstanding transaction at a time, with abort draining.
module dcache_port_arbiter
   import dcache_port_arbiter_pkg::*;
#(
   parameter int unsigned PA_WIDTH   = DCACHE_ARB_PA_WIDTH,
   parameter int unsigned DATA_WIDTH = DCACHE_ARB_DATA_WIDTH,
   parameter int unsigned STARVE_MAX = DCACHE_ARB_STARVE_MAX
) (
   input  logic                    rst_n,
   input  logic                    clk,

   input  logic                    lsu_req_i,
   input  logic [PA_WIDTH-1:0]     lsu_addr_i,
   input  logic                    lsu_w_en_i,
   input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] lsu_sel_byte_i,
   input  logic                    lsu_flush_i,
   output logic                    lsu_ack_o,
   output logic [DATA_WIDTH-1:0]   lsu_rdata_o,

   input  logic                    ptw_req_i,
   input  logic [PA_WIDTH-1:0]     ptw_addr_i,
   input  logic                    ptw_kill_i,
   output logic                    ptw_ack_o,
   output logic [DATA_WIDTH-1:0]   ptw_rdata_o,

   output logic                    dcache_req_o,
   output logic [PA_WIDTH-1:0]     dcache_addr_o,
   output logic                    dcache_w_en_o,
   output logic [DATA_WIDTH-1:0]   dcache_wdata_o,
   output logic [DATA_WIDTH/8-1:0] dcache_sel_byte_o,
   input  logic                    dcache_ack_i,
   input  logic [DATA_WIDTH-1:0]   dcache_rdata_i
);

   localparam int unsigned CNT_W = DCACHE_ARB_CNT_WIDTH;
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   type_dcache_arb_states_e state;
   logic [CNT_W-1:0]        starve_cnt;

   logic eligible_lsu;
   logic eligible_ptw;
   logic grant_lsu;
   logic grant_ptw;
   logic txn_done;

   // Arbitration: PTW first unless the LSU has waited out STARVE_MAX PTW grants.
   always_comb begin
      eligible_lsu = lsu_req_i & ~lsu_flush_i;
      eligible_ptw = ptw_req_i & ~ptw_kill_i;
      grant_lsu    = 1'b0;
      grant_ptw    = 1'b0;
      if (state == ARB_IDLE) begin
         if (eligible_lsu && (!eligible_ptw || starve_cnt == STARVE_LIM)) begin
            grant_lsu = 1'b1;
         end else if (eligible_ptw) begin
            grant_ptw = 1'b1;
         end
      end
      txn_done = (state != ARB_IDLE) & dcache_ack_i;
   end

   // Completion steering; an owner abort in the ack cycle swallows the ack.
   always_comb begin
      lsu_ack_o   = (state == ARB_LSU_BUSY) & dcache_ack_i & ~lsu_flush_i;
      ptw_ack_o   = (state == ARB_PTW_BUSY) & dcache_ack_i & ~ptw_kill_i;
      lsu_rdata_o = lsu_ack_o ? dcache_rdata_i : '0;
      ptw_rdata_o = ptw_ack_o ? dcache_rdata_i : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ARB_IDLE;
         starve_cnt        <= '0;
         dcache_req_o      <= 1'b0;
         dcache_addr_o     <= '0;
         dcache_w_en_o     <= 1'b0;
         dcache_wdata_o    <= '0;
         dcache_sel_byte_o <= '0;
      end else if (txn_done) begin
         state             <= ARB_IDLE;
         dcache_req_o      <= 1'b0;
         dcache_addr_o     <= '0;
         dcache_w_en_o     <= 1'b0;
         dcache_wdata_o    <= '0;
         dcache_sel_byte_o <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (grant_ptw) begin
                  state             <= ARB_PTW_BUSY;
                  dcache_req_o      <= 1'b1;
                  dcache_addr_o     <= ptw_addr_i;
                  dcache_w_en_o     <= 1'b0;
                  dcache_wdata_o    <= '0;
                  dcache_sel_byte_o <= '1;
                  starve_cnt        <= lsu_req_i ? starve_inc(starve_cnt, STARVE_LIM) : '0;
               end else if (grant_lsu) begin
                  state             <= ARB_LSU_BUSY;
                  dcache_req_o      <= 1'b1;
                  dcache_addr_o     <= lsu_addr_i;
                  dcache_w_en_o     <= lsu_w_en_i;
                  dcache_wdata_o    <= lsu_wdata_i;
                  dcache_sel_byte_o <= lsu_sel_byte_i;
                  starve_cnt        <= '0;
               end else if (!lsu_req_i) begin
                  starve_cnt <= '0;
               end
            end
            ARB_LSU_BUSY: begin
               if (lsu_flush_i) state <= ARB_DRAIN;
            end
            ARB_PTW_BUSY: begin
               if (ptw_kill_i) state <= ARB_DRAIN;
            end
            ARB_DRAIN: begin
               state <= ARB_DRAIN;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_dcache_port_arbiter;

   localparam int PA_W       = 34;
   localparam int D_W        = 32;
   localparam int SEL_W      = 4;
   localparam int STARVE_MAX = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             lsu_req, lsu_w_en, lsu_flush, lsu_ack;
   logic [PA_W-1:0]  lsu_addr;
   logic [D_W-1:0]   lsu_wdata, lsu_rdata;
   logic [SEL_W-1:0] lsu_sel;
   logic             ptw_req, ptw_kill, ptw_ack;
   logic [PA_W-1:0]  ptw_addr;
   logic [D_W-1:0]   ptw_rdata;
   logic             dc_req, dc_w_en, dc_ack;
   logic [PA_W-1:0]  dc_addr;
   logic [D_W-1:0]   dc_wdata, dc_rdata;
   logic [SEL_W-1:0] dc_sel;

   int n_checks = 0;
   int n_pass   = 0;

   dcache_port_arbiter dut (
      .rst_n(rst_n), .clk(clk),
      .lsu_req_i(lsu_req), .lsu_addr_i(lsu_addr), .lsu_w_en_i(lsu_w_en),
      .lsu_wdata_i(lsu_wdata), .lsu_sel_byte_i(lsu_sel), .lsu_flush_i(lsu_flush),
      .lsu_ack_o(lsu_ack), .lsu_rdata_o(lsu_rdata),
      .ptw_req_i(ptw_req), .ptw_addr_i(ptw_addr), .ptw_kill_i(ptw_kill),
      .ptw_ack_o(ptw_ack), .ptw_rdata_o(ptw_rdata),
      .dcache_req_o(dc_req), .dcache_addr_o(dc_addr), .dcache_w_en_o(dc_w_en),
      .dcache_wdata_o(dc_wdata), .dcache_sel_byte_o(dc_sel),
      .dcache_ack_i(dc_ack), .dcache_rdata_i(dc_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: who owns the port, whether the owner gave up, and what was issued.
   typedef enum int {M_NONE, M_LSU, M_PTW} owner_e;
   owner_e           m_owner;
   bit               m_aborted;
   int               m_starve;
   logic [PA_W-1:0]  m_addr;
   logic             m_w_en;
   logic [D_W-1:0]   m_wdata;
   logic [SEL_W-1:0] m_sel;

   function automatic void model_reset();
      m_owner   = M_NONE;
      m_aborted = 1'b0;
      m_starve  = 0;
   endfunction

   function automatic void model_step();
      bit el_l, el_p, lsu_wins, ptw_wins;
      if (m_owner != M_NONE) begin
         if (dc_ack) begin
            m_owner   = M_NONE;
            m_aborted = 1'b0;
         end else if ((m_owner == M_LSU && lsu_flush) || (m_owner == M_PTW && ptw_kill)) begin
            m_aborted = 1'b1;
         end
      end else begin
         el_l     = lsu_req && !lsu_flush;
         el_p     = ptw_req && !ptw_kill;
         lsu_wins = el_l && (!el_p || m_starve == STARVE_MAX);
         ptw_wins = el_p && !lsu_wins;
         if (ptw_wins) begin
            m_owner  = M_PTW;
            m_addr   = ptw_addr;
            m_w_en   = 1'b0;
            m_wdata  = '0;
            m_sel    = '1;
            m_starve = lsu_req ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
         end else if (lsu_wins) begin
            m_owner  = M_LSU;
            m_addr   = lsu_addr;
            m_w_en   = lsu_w_en;
            m_wdata  = lsu_wdata;
            m_sel    = lsu_sel;
            m_starve = 0;
         end else if (!lsu_req) begin
            m_starve = 0;
         end
      end
   endfunction

   // Per-cycle comparison; inputs are stable between the falling and next rising edge.
   always @(negedge clk) begin
      logic exp_lack, exp_pack;
      if (!rst_n) model_reset();
      exp_lack = (m_owner == M_LSU) && !m_aborted && dc_ack && !lsu_flush;
      exp_pack = (m_owner == M_PTW) && !m_aborted && dc_ack && !ptw_kill;
      chk("m_req", 64'(dc_req), 64'(m_owner != M_NONE));
      chk("m_lsu_ack", 64'(lsu_ack), 64'(exp_lack));
      chk("m_ptw_ack", 64'(ptw_ack), 64'(exp_pack));
      chk("m_lsu_rdata", 64'(lsu_rdata), exp_lack ? 64'(dc_rdata) : 64'd0);
      chk("m_ptw_rdata", 64'(ptw_rdata), exp_pack ? 64'(dc_rdata) : 64'd0);
      if (m_owner != M_NONE) begin
         chk("m_addr", 64'(dc_addr), 64'(m_addr));
         chk("m_w_en", 64'(dc_w_en), 64'(m_w_en));
         chk("m_wdata", 64'(dc_wdata), 64'(m_wdata));
         chk("m_sel", 64'(dc_sel), 64'(m_sel));
      end
      if (rst_n) model_step();
   end

   task automatic wait_req(input int max_cycles);
      int n = 0;
      while (!dc_req && n < max_cycles) begin
         step();
         n++;
      end
      chk("wait_req", 64'(dc_req), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [PA_W-1:0] starve_exp [5];

   initial begin
      rst_n = 1'b0;
      lsu_req = 0; lsu_addr = '0; lsu_w_en = 0; lsu_wdata = '0; lsu_sel = '0; lsu_flush = 0;
      ptw_req = 0; ptw_addr = '0; ptw_kill = 0;
      dc_ack = 0; dc_rdata = '0;
      repeat (3) step();
      chk("rst_req", 64'(dc_req), 64'd0);
      chk("rst_addr", 64'(dc_addr), 64'd0);
      chk("rst_acks", 64'({lsu_ack, ptw_ack}), 64'd0);
      rst_n = 1'b1;
      step();

      // Single LSU load
      lsu_req = 1; lsu_addr = 34'h0_8000_1004; lsu_w_en = 0; lsu_sel = 4'hF;
      step();
      chk("t1_req", 64'(dc_req), 64'd1);
      chk("t1_addr", 64'(dc_addr), 64'h0_8000_1004);
      chk("t1_w_en", 64'(dc_w_en), 64'd0);
      step(); step(); step();
      dc_ack = 1; dc_rdata = 32'hDEADBEEF;
      #1;
      chk("t1_ack", 64'(lsu_ack), 64'd1);
      chk("t1_rdata", 64'(lsu_rdata), 64'hDEADBEEF);
      chk("t1_no_ptw_ack", 64'(ptw_ack), 64'd0);
      step();
      dc_ack = 0; lsu_req = 0;
      #1;
      chk("t1_req_drop", 64'(dc_req), 64'd0);

      // Simultaneous requests: PTW first, LSU after
      lsu_req = 1; lsu_addr = 34'h1_0000_0040; lsu_w_en = 1; lsu_wdata = 32'h1234_5678; lsu_sel = 4'h3;
      ptw_req = 1; ptw_addr = 34'h0_0020_0008;
      step();
      chk("t2_ptw_addr", 64'(dc_addr), 64'h0_0020_0008);
      chk("t2_ptw_sel", 64'(dc_sel), 64'hF);
      chk("t2_ptw_w_en", 64'(dc_w_en), 64'd0);
      step();
      dc_ack = 1; dc_rdata = 32'hCAFE_0001;
      #1;
      chk("t2_ptw_ack", 64'(ptw_ack), 64'd1);
      chk("t2_ptw_rdata", 64'(ptw_rdata), 64'hCAFE_0001);
      chk("t2_lsu_ack0", 64'(lsu_ack), 64'd0);
      step();
      dc_ack = 0; ptw_req = 0;
      step();
      chk("t2_lsu_addr", 64'(dc_addr), 64'h1_0000_0040);
      chk("t2_lsu_w_en", 64'(dc_w_en), 64'd1);
      chk("t2_lsu_wdata", 64'(dc_wdata), 64'h1234_5678);
      chk("t2_lsu_sel", 64'(dc_sel), 64'h3);
      dc_ack = 1; dc_rdata = 32'h0;
      step();
      dc_ack = 0; lsu_req = 0; lsu_w_en = 0; lsu_sel = 4'hF;
      step();

      // Starvation: PTW x4 then LSU x1
      starve_exp[0] = 34'h0_0030_0000; starve_exp[1] = 34'h0_0030_0008;
      starve_exp[2] = 34'h0_0030_0010; starve_exp[3] = 34'h0_0030_0018;
      starve_exp[4] = 34'h2_0000_0100;
      lsu_req = 1; lsu_addr = 34'h2_0000_0100;
      ptw_req = 1; ptw_addr = 34'h0_0030_0000;
      for (int g = 0; g < 5; g++) begin
         wait_req(20);
         chk("t3_grant_addr", 64'(dc_addr), 64'(starve_exp[g]));
         step();
         dc_ack = 1; dc_rdata = D_W'(32'hA000_0000 + g);
         #1;
         chk("t3_owner_ack", 64'({lsu_ack, ptw_ack}), (g < 4) ? 64'b01 : 64'b10);
         step();
         dc_ack = 0;
         if (g < 4) ptw_addr = ptw_addr + 34'd8;
         else begin
            lsu_req = 0; ptw_req = 0;
         end
      end
      step();

      // PTW kill during BUSY: drain until ack, no PTW ack
      ptw_req = 1; ptw_addr = 34'h0_0040_0000;
      step();
      chk("t4_req", 64'(dc_req), 64'd1);
      step();
      ptw_kill = 1; ptw_req = 0;
      step();
      ptw_kill = 0;
      chk("t4_drain_req_a", 64'(dc_req), 64'd1);
      step();
      chk("t4_drain_req_b", 64'(dc_req), 64'd1);
      step();
      dc_ack = 1; dc_rdata = 32'h5555_AAAA;
      #1;
      chk("t4_ptw_ack0", 64'(ptw_ack), 64'd0);
      chk("t4_ptw_rdata0", 64'(ptw_rdata), 64'd0);
      step();
      dc_ack = 0;
      chk("t4_req_drop", 64'(dc_req), 64'd0);
      lsu_req = 1; lsu_addr = 34'h0_0000_0200;
      step();
      chk("t4_regrant", 64'(dc_addr), 64'h0_0000_0200);
      dc_ack = 1; dc_rdata = 32'h0BAD_F00D;
      #1;
      chk("t4_lsu_ack", 64'(lsu_ack), 64'd1);
      step();
      dc_ack = 0; lsu_req = 0;
      step();

      // LSU flush coincident with ack; non-owner kill ignored; flush in IDLE
      lsu_req = 1; lsu_addr = 34'h0_0000_0300;
      step();
      ptw_kill = 1;
      step();
      ptw_kill = 0;
      dc_ack = 1; dc_rdata = 32'h7777_7777; lsu_flush = 1;
      #1;
      chk("t5_flush_ack0", 64'(lsu_ack), 64'd0);
      chk("t5_flush_rdata0", 64'(lsu_rdata), 64'd0);
      step();
      dc_ack = 0; lsu_flush = 0; lsu_addr = 34'h0_0000_0304;
      step();
      chk("t5_next_grant", 64'(dc_req), 64'd1);
      chk("t5_next_addr", 64'(dc_addr), 64'h0_0000_0304);
      ptw_kill = 1;
      dc_ack = 1; dc_rdata = 32'h1357_9BDF;
      #1;
      chk("t5_nonowner_ack", 64'(lsu_ack), 64'd1);
      chk("t5_nonowner_rdata", 64'(lsu_rdata), 64'h1357_9BDF);
      step();
      dc_ack = 0; ptw_kill = 0; lsu_req = 0;
      step();
      lsu_req = 1; lsu_flush = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_idle_flush", 64'(dc_req), 64'd0);
      end
      lsu_req = 0; lsu_flush = 0;
      step();

      // Reset mid LSU_BUSY, then a stray ack
      lsu_req = 1; lsu_addr = 34'h3_0000_0000; lsu_w_en = 1; lsu_wdata = 32'hFFFF_0000;
      step();
      chk("t6_busy", 64'(dc_req), 64'd1);
      rst_n = 0;
      #1;
      chk("t6_rst_req", 64'(dc_req), 64'd0);
      chk("t6_rst_regs", 64'({dc_addr, dc_w_en}), 64'd0);
      chk("t6_rst_wdata", 64'({dc_wdata, dc_sel}), 64'd0);
      chk("t6_rst_acks", 64'({lsu_ack, ptw_ack}), 64'd0);
      lsu_req = 0; lsu_w_en = 0;
      step();
      rst_n = 1;
      step();
      dc_ack = 1; dc_rdata = 32'h9999_9999;
      #1;
      chk("t6_stray_acks", 64'({lsu_ack, ptw_ack}), 64'd0);
      chk("t6_stray_rdata", 64'(lsu_rdata), 64'd0);
      step();
      dc_ack = 0;
      step();
      chk("t6_idle", 64'(dc_req), 64'd0);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
